// File: rtl/io_posted_write_ctl.sv
// io_posted_write_ctl
//   Posted-write buffer and I/O bus sequencer placed ahead of the FSB
//   DTACK/VPA stage. Postable I/O writes are pushed into a small FIFO and
//   acknowledged at once. The FIFO then drains to the slow I/O bus in the
//   background. Non-posted cycles (reads and unpostable writes) run on the
//   I/O bus only after every buffered write has completed.
//
// Ports
//   FCLK, RESET        clock, asynchronous active-high reset
//   BACT, IOCS, IOPWCS CPU cycle active / I/O decode / postable decode
//   WR, A, D, DS       CPU direction, address, write data, byte strobes
//   IOPWReady          posted write accepted for the current CPU cycle
//   IONPReady          non-posted cycle finished for the current CPU cycle
//   RDATA              read data captured from the I/O bus
//   IOREQ, IOWR        I/O bus request (held until IOACK) and direction
//   IOA, IOD, IODS     I/O bus address, write data, byte strobes
//   IOACK, IOQ         I/O bus completion pulse and read data
module io_posted_write_ctl #(
    parameter int DEPTH = 2,
    parameter int AW    = 23,
    parameter int DW    = 16
) (
    input  logic          FCLK,
    input  logic          RESET,
    input  logic          BACT,
    input  logic          IOCS,
    input  logic          IOPWCS,
    input  logic          WR,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    input  logic [1:0]    DS,
    output logic          IOPWReady,
    output logic          IONPReady,
    output logic [DW-1:0] RDATA,
    output logic          IOREQ,
    output logic          IOWR,
    output logic [AW-1:0] IOA,
    output logic [DW-1:0] IOD,
    output logic [1:0]    IODS,
    input  logic          IOACK,
    input  logic [DW-1:0] IOQ
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW + 2;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, PWDRAIN, NP, NPDONE} state_t;

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    // done: this CPU cycle already pushed or completed its NP access.
    // done_pw / done_np remember which, to drive the matching ready output.
    logic done;
    logic done_pw;
    logic done_np;

    logic          full;
    logic          empty;
    logic          pop;
    logic          pw_req;
    logic          push;
    logic          np_req;
    logic [EW-1:0] head;

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    assign pop    = (state == PWDRAIN) && IOACK;
    assign pw_req = BACT && IOCS && IOPWCS && WR && !done;
    // A full FIFO still accepts the write on the edge where the head pops.
    assign push   = pw_req && (!full || pop);
    assign np_req = BACT && IOCS && !(IOPWCS && WR) && !done;
    assign head   = mem[rptr];

    // FIFO storage carries data only, so it is left out of reset.
    always_ff @(posedge FCLK) begin
        if (push) begin
            mem[wptr] <= {A, D, DS};
        end
    end

    always_ff @(posedge FCLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            done      <= 1'b0;
            done_pw   <= 1'b0;
            done_np   <= 1'b0;
            IOPWReady <= 1'b0;
            IONPReady <= 1'b0;
            RDATA     <= '0;
            IOREQ     <= 1'b0;
            IOWR      <= 1'b0;
            IOA       <= '0;
            IOD       <= '0;
            IODS      <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            if (!BACT) begin
                done    <= 1'b0;
                done_pw <= 1'b0;
                done_np <= 1'b0;
            end else begin
                if (push) begin
                    done    <= 1'b1;
                    done_pw <= 1'b1;
                end
                if ((state == NP) && IOACK) begin
                    done    <= 1'b1;
                    done_np <= 1'b1;
                end
            end

            // Ready outputs trail their flag by one edge and drop with BACT.
            IOPWReady <= BACT && done_pw;
            IONPReady <= BACT && done_np;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        IOA   <= head[EW-1:DW+2];
                        IOD   <= head[DW+1:2];
                        IODS  <= head[1:0];
                        IOWR  <= 1'b1;
                        IOREQ <= 1'b1;
                        state <= PWDRAIN;
                    end else if (np_req) begin
                        IOA   <= A;
                        IOD   <= D;
                        IODS  <= DS;
                        IOWR  <= WR;
                        IOREQ <= 1'b1;
                        state <= NP;
                    end
                end
                PWDRAIN: begin
                    // Returning through IDLE guarantees a low IOREQ cycle.
                    if (IOACK) begin
                        IOREQ <= 1'b0;
                        state <= IDLE;
                    end
                end
                NP: begin
                    if (IOACK) begin
                        IOREQ <= 1'b0;
                        if (!IOWR) begin
                            RDATA <= IOQ;
                        end
                        state <= NPDONE;
                    end
                end
                NPDONE: begin
                    if (!BACT) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_posted_write_ctl.sv
module tb_io_posted_write_ctl;

    localparam int DEPTH = 2;
    localparam int AW    = 23;
    localparam int DW    = 16;

    logic          FCLK = 1'b0;
    logic          RESET;
    logic          BACT, IOCS, IOPWCS, WR;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [1:0]    DS;
    logic          IOPWReady, IONPReady;
    logic [DW-1:0] RDATA;
    logic          IOREQ, IOWR;
    logic [AW-1:0] IOA;
    logic [DW-1:0] IOD;
    logic [1:0]    IODS;
    logic          IOACK;
    logic [DW-1:0] IOQ;

    int vec  = 0;
    int errs = 0;

    // Expected I/O bus requests, packed as {IOA, IOD, IODS, IOWR}.
    logic [AW+DW+2:0] sb[$];

    io_posted_write_ctl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .FCLK(FCLK), .RESET(RESET), .BACT(BACT), .IOCS(IOCS), .IOPWCS(IOPWCS),
        .WR(WR), .A(A), .D(D), .DS(DS), .IOPWReady(IOPWReady),
        .IONPReady(IONPReady), .RDATA(RDATA), .IOREQ(IOREQ), .IOWR(IOWR),
        .IOA(IOA), .IOD(IOD), .IODS(IODS), .IOACK(IOACK), .IOQ(IOQ)
    );

    always #5 FCLK = ~FCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge FCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0; WR = 1'b0;
        A = '0; D = '0; DS = 2'b00;
    endtask

    // One complete posted-write CPU cycle; the FIFO must have room.
    task automatic pw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] ds);
        A = a; D = d; DS = ds;
        BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b1; WR = 1'b1;
        sb.push_back({a, d, ds, 1'b1});
        tick();
        chk("pw_rdy_push_edge", IOPWReady, 0);
        tick();
        chk("pw_rdy", IOPWReady, 1);
        BACT = 1'b0;
        tick();
        chk("pw_rdy_clr", IOPWReady, 0);
        idle_bus();
    endtask

    // Wait for the next I/O request, check it against the scoreboard, ack it.
    task automatic ack(input logic [DW-1:0] q);
        logic [AW+DW+2:0] exp;
        int n = 0;
        while (!IOREQ && n < 50) begin
            tick();
            n++;
        end
        chk("ioreq_seen", IOREQ, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        chk("iobus_req", {IOA, IOD, IODS, IOWR}, exp);
        IOQ = q;
        IOACK = 1'b1;
        tick();
        IOACK = 1'b0;
        IOQ = '0;
        chk("ioreq_drop", IOREQ, 0);
    endtask

    initial begin
        RESET = 1'b1;
        IOACK = 1'b0;
        IOQ   = '0;
        idle_bus();
        tick();
        tick();
        chk("reset_outputs", {IOPWReady, IONPReady, RDATA, IOREQ, IOWR, IOA, IOD, IODS}, 0);
        RESET = 1'b0;
        tick();

        // Single posted write
        pw(23'h0EFE00, 16'h1234, 2'b11);
        ack('0);
        tick();
        chk("single_drained", IOREQ, 0);
        tick();
        chk("single_no_reissue", IOREQ, 0);

        // Full FIFO: third write waits until the head pops
        pw(23'h000200, 16'h1111, 2'b11);
        pw(23'h000202, 16'h2222, 2'b01);
        A = 23'h000204; D = 16'h3333; DS = 2'b10;
        BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b1; WR = 1'b1;
        sb.push_back({23'h000204, 16'h3333, 2'b10, 1'b1});
        tick();
        tick();
        tick();
        chk("full_wait_rdy", IOPWReady, 0);
        ack('0);
        chk("full_pop_edge_rdy", IOPWReady, 0);
        tick();
        chk("full_push_rdy", IOPWReady, 1);
        BACT = 1'b0;
        tick();
        chk("full_rdy_clr", IOPWReady, 0);
        idle_bus();
        ack('0);
        ack('0);
        tick();
        tick();
        chk("full_drained", IOREQ, 0);
        chk("full_sb_empty", sb.size(), 0);

        // Read waits behind a buffered write
        pw(23'h0EFE02, 16'h5A5A, 2'b11);
        A = 23'h0DFE00; D = '0; DS = 2'b11;
        BACT = 1'b1; IOCS = 1'b1; IOPWCS = 1'b0; WR = 1'b0;
        sb.push_back({23'h0DFE00, 16'h0000, 2'b11, 1'b0});
        tick();
        tick();
        chk("rd_np_wait", IONPReady, 0);
        ack('0);
        chk("rd_np_after_wr", IONPReady, 0);
        ack(16'hBEEF);
        chk("rd_rdata", RDATA, 16'hBEEF);
        chk("rd_np_ack_edge", IONPReady, 0);
        tick();
        chk("rd_np_rdy", IONPReady, 1);
        tick();
        tick();
        chk("rd_np_hold", IONPReady, 1);
        chk("rd_pw_low", IOPWReady, 0);
        BACT = 1'b0;
        tick();
        chk("rd_np_clr", IONPReady, 0);
        idle_bus();
        tick();
        chk("rd_rdata_keep", RDATA, 16'hBEEF);
        chk("rd_no_reissue", IOREQ, 0);

        // Non-I/O cycle while a buffered write drains
        pw(23'h000300, 16'hC0DE, 2'b11);
        BACT = 1'b1; IOCS = 1'b0; IOPWCS = 1'b1; WR = 1'b1; A = 23'h000400; D = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("nonio_pw", IOPWReady, 0);
            chk("nonio_np", IONPReady, 0);
            if (IOACK) begin
                IOACK = 1'b0;
            end else if (IOREQ) begin
                chk("nonio_drain", {IOA, IOD, IODS, IOWR},
                    (sb.size() > 0) ? sb.pop_front() : '1);
                IOACK = 1'b1;
            end
        end
        IOACK = 1'b0;
        idle_bus();
        tick();
        chk("nonio_sb_empty", sb.size(), 0);
        chk("nonio_idle", IOREQ, 0);

        // Pointer wrap: 2*DEPTH+1 writes, data 0..2*DEPTH
        for (int i = 0; i <= 2 * DEPTH; i++) begin
            pw(23'h000500 + 23'(2 * i), 16'(i), 2'b11);
            if ((i % 2 == 1) || (i == 2 * DEPTH)) begin
                while (sb.size() > 0) ack('0);
            end
        end
        tick();
        chk("wrap_idle", IOREQ, 0);

        // Reset in the middle of draining with two buffered entries
        pw(23'h000600, 16'h00AA, 2'b11);
        pw(23'h000602, 16'h00BB, 2'b11);
        chk("rst_pre_req", IOREQ, 1);
        @(posedge FCLK);
        #3;
        RESET = 1'b1;
        #1;
        chk("rst_async_ioreq", IOREQ, 0);
        chk("rst_async_outs", {IOPWReady, IONPReady, RDATA, IOWR, IOA, IOD, IODS}, 0);
        sb.delete();
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_no_ioreq", IOREQ, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
